// File: rtl/fifo_rd_stream.sv
// rtl/fifo_rd_stream.sv - FIFO read-side drain into a skid-buffered valid/ready packet stream
// Optional STATS_EN macro adds word_cnt / pkt_cnt_out counters.
module fifo_rd_stream #(
    parameter int FIFO_WIDTH = 16,
    parameter int BUF_DEPTH  = 4,
    parameter int PKT_LEN    = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic [FIFO_WIDTH-1:0] fifo_data_out,
    input  logic                  fifo_empty,
    input  logic                  fifo_underflow,
    output logic                  fifo_rd_en,
    output logic [FIFO_WIDTH-1:0] m_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic                  m_last,
    output logic                  busy,
    output logic                  err_underflow
`ifdef STATS_EN
    ,
    output logic [31:0]           word_cnt,
    output logic [15:0]           pkt_cnt_out
`endif
);

    localparam int CW = $clog2(BUF_DEPTH + 1);
    localparam int AW = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
    localparam int PW = (PKT_LEN > 1) ? $clog2(PKT_LEN) : 1;
    localparam logic [CW:0]   L_DEPTH    = (CW+1)'(BUF_DEPTH);
    localparam logic [AW-1:0] L_PTR_LAST = AW'(BUF_DEPTH - 1);
    localparam logic [PW-1:0] L_PKT_LAST = PW'(PKT_LEN - 1);

    typedef enum logic {
        S_IDLE,
        S_IN_PKT
    } pkt_state_t;

    logic [FIFO_WIDTH-1:0] r_mem [0:BUF_DEPTH-1];
    logic [AW-1:0]         r_wr_ptr;
    logic [AW-1:0]         r_rd_ptr;
    logic [CW-1:0]         r_count;
    logic                  r_inflight;
    logic                  r_issue_empty;
    logic                  r_err;
    logic [PW-1:0]         r_pkt_cnt;
    pkt_state_t            r_state;
    pkt_state_t            w_state_nxt;

    logic [CW:0]           w_occupancy;
    logic                  w_push;
    logic                  w_pop;
    logic                  w_last;

    function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
        return (p == L_PTR_LAST) ? '0 : p + AW'(1);
    endfunction

    // Every in-flight read already owns a buffer slot, so the gate never overfills.
    assign w_occupancy = {1'b0, r_count} + {{CW{1'b0}}, r_inflight};
    assign fifo_rd_en  = en & ~fifo_empty & ~rst & (w_occupancy < L_DEPTH);

    assign m_valid       = (r_count != '0);
    assign m_data        = m_valid ? r_mem[r_rd_ptr] : '0;
    assign w_last        = m_valid & (r_pkt_cnt == L_PKT_LAST);
    assign m_last        = w_last;
    assign w_push        = r_inflight;
    assign w_pop         = m_valid & m_ready;
    assign busy          = r_inflight | m_valid;
    assign err_underflow = r_err;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_inflight    <= 1'b0;
            r_issue_empty <= 1'b0;
        end else begin
            r_inflight    <= fifo_rd_en;
            r_issue_empty <= fifo_rd_en & fifo_empty;
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= fifo_data_out;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= ptr_inc(r_wr_ptr);
            end
            if (w_pop) begin
                r_rd_ptr <= ptr_inc(r_rd_ptr);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Inflight with an empty FIFO at issue cannot happen given the read gate; kept as a checker.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_err <= 1'b0;
        end else if (fifo_underflow || (r_inflight && r_issue_empty)) begin
            r_err <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_pkt_cnt <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_pop) begin
                r_pkt_cnt <= w_last ? '0 : r_pkt_cnt + PW'(1);
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_pop && (PKT_LEN > 1)) begin
                    w_state_nxt = S_IN_PKT;
                end
            end
            S_IN_PKT: begin
                if (w_pop && w_last) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

`ifdef STATS_EN
    logic [31:0] r_word_cnt;
    logic [15:0] r_pkt_cnt_out;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_word_cnt    <= '0;
            r_pkt_cnt_out <= '0;
        end else if (w_pop) begin
            r_word_cnt <= r_word_cnt + 32'd1;
            if (w_last) begin
                r_pkt_cnt_out <= r_pkt_cnt_out + 16'd1;
            end
        end
    end

    assign word_cnt    = r_word_cnt;
    assign pkt_cnt_out = r_pkt_cnt_out;
`endif

endmodule

// File: tb/tb_fifo_rd_stream.sv
// tb/tb_fifo_rd_stream.sv - scoreboard bench for fifo_rd_stream with a queue-based upstream FIFO model
module tb_fifo_rd_stream;

    localparam int W = 16;
    localparam int P = 8;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         en = 1'b0;
    logic [W-1:0] fifo_data_out = '0;
    logic         fifo_empty = 1'b1;
    logic         fifo_underflow = 1'b0;
    logic         m_ready = 1'b0;
    logic         fifo_rd_en;
    logic [W-1:0] m_data;
    logic         m_valid;
    logic         m_last;
    logic         busy;
    logic         err_underflow;
`ifdef STATS_EN
    logic [31:0]  word_cnt;
    logic [15:0]  pkt_cnt_out;
`endif

    fifo_rd_stream #(.FIFO_WIDTH(W), .BUF_DEPTH(4), .PKT_LEN(P)) dut (
        .clk(clk), .rst(rst), .en(en),
        .fifo_data_out(fifo_data_out), .fifo_empty(fifo_empty),
        .fifo_underflow(fifo_underflow), .fifo_rd_en(fifo_rd_en),
        .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
        .m_last(m_last), .busy(busy), .err_underflow(err_underflow)
`ifdef STATS_EN
        , .word_cnt(word_cnt), .pkt_cnt_out(pkt_cnt_out)
`endif
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass = 0;
    logic [W-1:0] fifo_q[$];
    logic [W:0]   exp_q[$];
    logic [W:0]   exp_w;
    int widx = 0;
    int cyc = 0;
    int rd_cnt = 0, rd_first = 0, rd_last = 0;
    int pop_cnt = 0, pop_first = 0, pop_last = 0;
    logic rd_s = 1'b0;
    logic hold = 1'b0;
    logic [W-1:0] hold_d = '0;
    logic [W-1:0] first_w;
    int t;
    int loaded;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endfunction

    // Reference: words leave in load order; every P-th word since reset carries last.
    task automatic load(input logic [W-1:0] w);
        fifo_q.push_back(w);
        exp_q.push_back({((widx % P) == P - 1), w});
        widx++;
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_idle(input string name, input int max);
        int k = 0;
        while ((fifo_q.size() != 0 || busy || exp_q.size() != 0) && k < max) begin
            tick(1);
            k++;
        end
        chk(name, 32'(k < max), 32'd1);
    endtask

    always @(negedge clk) begin
        cyc++;
        rd_s = fifo_rd_en;
        if (fifo_rd_en) begin
            if (rd_cnt == 0) rd_first = cyc;
            rd_last = cyc;
            rd_cnt++;
        end
    end

    // Upstream FIFO model: one-cycle read latency.
    always @(posedge clk) begin
        #1;
        if (rd_s) begin
            if (fifo_q.size() > 0) fifo_data_out = fifo_q.pop_front();
            else chk("fifo_model_read_when_empty", 32'd1, 32'd0);
        end
        fifo_empty = (fifo_q.size() == 0);
    end

    always @(negedge clk) begin
        if (!rst) begin
            if (hold) begin
                chk("hold_valid", 32'(m_valid), 32'd1);
                chk("hold_data", 32'(m_data), 32'(hold_d));
            end
            if (m_valid && m_ready) begin
                if (pop_cnt == 0) pop_first = cyc;
                pop_last = cyc;
                pop_cnt++;
                if (exp_q.size() == 0) begin
                    chk("unexpected_word", 32'({m_last, m_data}), 32'hFFFF_FFFF);
                end else begin
                    exp_w = exp_q.pop_front();
                    chk("stream_word", 32'({m_last, m_data}), 32'(exp_w));
                end
            end
            hold = m_valid & ~m_ready;
            hold_d = m_data;
        end else begin
            hold = 1'b0;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, checks so far %0d", n_checks);
        $fatal(1);
    end

    initial begin
        // Reset
        tick(2);
        chk("rst_rd_en", 32'(fifo_rd_en), 32'd0);
        chk("rst_m_valid", 32'(m_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_err", 32'(err_underflow), 32'd0);
        chk("rst_m_last", 32'(m_last), 32'd0);
        rst = 1'b0;
        en = 1'b1;
        tick(1);
        chk("idle_rd_en", 32'(fifo_rd_en), 32'd0);
        chk("idle_m_valid", 32'(m_valid), 32'd0);
        chk("idle_busy", 32'(busy), 32'd0);

        // Full-throughput stream 1..16
        m_ready = 1'b1;
        rd_cnt = 0;
        pop_cnt = 0;
        for (int i = 1; i <= 16; i++) load(W'(i));
        wait_idle("t2_drain", 200);
        chk("t2_rd_count", 32'(rd_cnt), 32'd16);
        chk("t2_rd_consecutive", 32'(rd_last - rd_first), 32'd15);
        chk("t2_pop_count", 32'(pop_cnt), 32'd16);
        chk("t2_pop_consecutive", 32'(pop_last - pop_first), 32'd15);

        // Backpressure fills the skid buffer
        m_ready = 1'b0;
        rd_cnt = 0;
        for (int i = 0; i < 10; i++) load(W'($urandom));
        first_w = fifo_q[0];
        tick(20);
        chk("t3_reads_issued", 32'(rd_cnt), 32'd4);
        chk("t3_rd_en_blocked", 32'(fifo_rd_en), 32'd0);
        chk("t3_m_valid", 32'(m_valid), 32'd1);
        chk("t3_head_data", 32'(m_data), 32'(first_w));
        chk("t3_nothing_popped", 32'(exp_q.size()), 32'd10);
        m_ready = 1'b1;
        wait_idle("t3_drain", 200);
        chk("t3_total_reads", 32'(rd_cnt), 32'd10);

        // en drops mid-stream
        pop_cnt = 0;
        for (int i = 0; i < 12; i++) load(W'($urandom));
        t = 0;
        while (pop_cnt < 3 && t < 100) begin
            @(negedge clk);
            t++;
        end
        chk("t4_three_popped", 32'(t < 100), 32'd1);
        en = 1'b0;
        rd_cnt = 0;
        tick(10);
        chk("t4_no_reads", 32'(rd_cnt), 32'd0);
        chk("t4_drained_busy", 32'(busy), 32'd0);
        chk("t4_inflight_delivered", 32'(exp_q.size()), 32'(fifo_q.size()));
        en = 1'b1;
        wait_idle("t4_resume_drain", 200);

        // Random en / m_ready / arrivals
        loaded = 0;
        for (int c = 0; c < 300; c++) begin
            if ($urandom_range(0, 3) == 0 && loaded < 60) begin
                load(W'($urandom));
                loaded++;
            end
            en = ($urandom_range(0, 4) != 0);
            m_ready = ($urandom_range(0, 2) != 0);
            tick(1);
        end
        while (loaded < 60) begin
            load(W'($urandom));
            loaded++;
        end
        en = 1'b1;
        m_ready = 1'b1;
        wait_idle("rand_drain", 500);

        // Sticky underflow
        chk("t5_err_before", 32'(err_underflow), 32'd0);
        fifo_underflow = 1'b1;
        tick(1);
        fifo_underflow = 1'b0;
        tick(1);
        chk("t5_err_set", 32'(err_underflow), 32'd1);
        tick(10);
        chk("t5_err_sticky", 32'(err_underflow), 32'd1);

        // Reset one cycle after a read strobe
        m_ready = 1'b0;
        for (int i = 0; i < 3; i++) load(W'($urandom));
        t = 0;
        while (!fifo_rd_en && t < 20) begin
            @(negedge clk);
            t++;
        end
        chk("t6_rd_seen", 32'(t < 20), 32'd1);
        @(posedge clk);
        #1;
        rst = 1'b1;
        en = 1'b0;
        tick(1);
        chk("t6_rst_m_valid", 32'(m_valid), 32'd0);
        chk("t6_rst_busy", 32'(busy), 32'd0);
        chk("t6_rst_err_clear", 32'(err_underflow), 32'd0);
        rst = 1'b0;
        fifo_q.delete();
        exp_q.delete();
        widx = 0;
        tick(1);
        chk("t6_word_dropped", 32'(m_valid), 32'd0);
        chk("t6_idle_busy", 32'(busy), 32'd0);
`ifdef STATS_EN
        chk("t6_word_cnt_rst", word_cnt, 32'd0);
        chk("t6_pkt_cnt_out_rst", 32'(pkt_cnt_out), 32'd0);
`endif
        tick(2);
        en = 1'b1;
        m_ready = 1'b1;
        for (int i = 0; i < 8; i++) load(W'($urandom));
        wait_idle("t6_packet_after_reset", 200);
`ifdef STATS_EN
        chk("t6_word_cnt", word_cnt, 32'd8);
        chk("t6_pkt_cnt_out", 32'(pkt_cnt_out), 32'd1);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
